// File: rtl/stopwatch_pkg.sv
// Shared BCD constants and helpers for the stopwatch count core.
// Latency: n/a (package). Backpressure: n/a.
package stopwatch_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // A non-decimal nibble on the load path is pinned to 9 rather than propagated.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the carry/borrow chain; co flags the digit sitting at its roll point.
// Latency: q updates on the enabling edge. Backpressure: none.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       co
);

  // Not gated by en: the top ANDs these to find the terminal count before stepping.
  assign co = (dir == DIR_UP) ? (q == BCD_MAX) : (q == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= bcd_clamp(ld_val);
    end else if (en) begin
      if (dir == DIR_UP) begin
        q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      end else begin
        q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Stopwatch core: run-gated prescaler driving an up/down BCD chain with load, clear and lap.
// Latency: count moves on the step edge; tick/tc_pulse follow one cycle later. Backpressure: none.
module bcd_stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10_000_000,
  parameter bit WRAP       = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        clear,
  input  logic                        rev,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  input  logic                        lap,
  output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
  output logic [BCD_W*NUM_DIGITS-1:0] lap_bcd,
  output logic                        lap_valid,
  output logic                        tick,
  output logic                        tc_pulse
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc;
  logic                  step_en;
  logic                  step_att;
  logic                  step_go;
  logic                  at_tc;
  logic [NUM_DIGITS-1:0] co;
  logic [NUM_DIGITS:0]   chain;

  assign step_en  = run && (presc == PRESC_MAX);
  assign step_att = step_en && !clear && !load;
  assign at_tc    = &co;
  // Saturating builds refuse the step entirely so no digit moves at the terminal count.
  assign step_go  = step_att && (WRAP || !at_tc);
  assign chain[0] = step_go;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] && co[i];

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .en     (chain[i]),
      .dir    (rev),
      .clr    (clear),
      .ld     (load),
      .ld_val (load_val[i*BCD_W +: BCD_W]),
      .q      (count_bcd[i*BCD_W +: BCD_W]),
      .co     (co[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (clear || load) begin
      presc <= '0;
    end else if (run) begin
      presc <= step_en ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick     <= 1'b0;
      tc_pulse <= 1'b0;
    end else begin
      tick     <= step_att;
      tc_pulse <= step_att && at_tc;
    end
  end

  // count_bcd here is the pre-update value, so a lap on a step or load edge sees the old count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else if (lap) begin
      lap_bcd   <= count_bcd;
      lap_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter: wrap and saturate builds side by side,
// checked each cycle against a decimal-arithmetic model plus literal spot checks.
module tb_bcd_stopwatch_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset, run, clear, rev, load, lap;
  logic [7:0] load_val;

  logic [7:0] count_w, lap_w, count_s, lap_s;
  logic       lv_w, tick_w, tc_w, lv_s, tick_s, tc_s;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  typedef struct {
    int cnt;
    int presc;
    int lapv;
    bit lv;
    bit tk;
    bit tc;
  } mstate_t;

  mstate_t mw = '{cnt: 0, presc: 0, lapv: 0, lv: 0, tk: 0, tc: 0};
  mstate_t ms = '{cnt: 0, presc: 0, lapv: 0, lv: 0, tk: 0, tc: 0};

  bcd_stopwatch_counter #(.NUM_DIGITS(2), .TICK_DIV(TD), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .rev(rev), .load(load),
    .load_val(load_val), .lap(lap), .count_bcd(count_w), .lap_bcd(lap_w),
    .lap_valid(lv_w), .tick(tick_w), .tc_pulse(tc_w)
  );

  bcd_stopwatch_counter #(.NUM_DIGITS(2), .TICK_DIV(TD), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .rev(rev), .load(load),
    .load_val(load_val), .lap(lap), .count_bcd(count_s), .lap_bcd(lap_s),
    .lap_valid(lv_s), .tick(tick_s), .tc_pulse(tc_s)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int load_dec();
    int d1;
    int d0;
    d1 = int'(load_val[7:4]);
    d0 = int'(load_val[3:0]);
    if (d1 > 9) d1 = 9;
    if (d0 > 9) d0 = 9;
    return d1 * 10 + d0;
  endfunction

  // Model: count kept as a plain decimal integer 0..99, prescaler as a phase 0..TD-1.
  function automatic mstate_t mnext(input mstate_t s, input bit wrap);
    mstate_t n;
    n = s;
    n.tk = 1'b0;
    n.tc = 1'b0;
    if (!reset) begin
      n = '{cnt: 0, presc: 0, lapv: 0, lv: 0, tk: 0, tc: 0};
    end else if (clear) begin
      n.cnt = 0; n.presc = 0; n.lapv = 0; n.lv = 1'b0;
    end else begin
      if (lap) begin
        n.lapv = s.cnt;
        n.lv   = 1'b1;
      end
      if (load) begin
        n.cnt   = load_dec();
        n.presc = 0;
      end else if (run) begin
        n.presc = (s.presc + 1) % TD;
        if (s.presc == TD - 1) begin
          n.tk = 1'b1;
          if (!rev) begin
            if (s.cnt == 99) begin n.tc = 1'b1; n.cnt = wrap ? 0 : 99; end
            else n.cnt = s.cnt + 1;
          end else begin
            if (s.cnt == 0) begin n.tc = 1'b1; n.cnt = wrap ? 99 : 0; end
            else n.cnt = s.cnt - 1;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mw <= mnext(mw, 1'b1);
    ms <= mnext(ms, 1'b0);
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("w_count", count_w, to_bcd(mw.cnt));
      chk("w_lap",   lap_w,   to_bcd(mw.lapv));
      chk("w_lapv",  {7'd0, lv_w},   {7'd0, mw.lv});
      chk("w_tick",  {7'd0, tick_w}, {7'd0, mw.tk});
      chk("w_tc",    {7'd0, tc_w},   {7'd0, mw.tc});
      chk("s_count", count_s, to_bcd(ms.cnt));
      chk("s_lap",   lap_s,   to_bcd(ms.lapv));
      chk("s_lapv",  {7'd0, lv_s},   {7'd0, ms.lv});
      chk("s_tick",  {7'd0, tick_s}, {7'd0, ms.tk});
      chk("s_tc",    {7'd0, tc_s},   {7'd0, ms.tc});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; clear = 1'b0; rev = 1'b0;
    load = 1'b0; lap = 1'b0; load_val = 8'h00;

    // reset and basic stepping
    cyc(2);
    chk("t1_rst_count", count_w, 8'h00);
    chk("t1_rst_tick",  {7'd0, tick_w}, 8'h00);
    reset = 1'b1;
    cyc(12);
    chk("t1_count_12clk", count_w, 8'h03);
    chk("t1_tick",        {7'd0, tick_w}, 8'h01);

    // up-count terminal: wrap vs saturate
    load = 1'b1; load_val = 8'h98;
    cyc(1);
    load = 1'b0;
    cyc(8);
    chk("t2_wrap_count", count_w, 8'h00);
    chk("t2_sat_count",  count_s, 8'h99);
    chk("t2_wrap_tc",    {7'd0, tc_w}, 8'h01);
    chk("t2_sat_tc",     {7'd0, tc_s}, 8'h01);
    cyc(4);
    chk("t2_wrap_next",  count_w, 8'h01);
    chk("t2_wrap_tc2",   {7'd0, tc_w}, 8'h00);
    chk("t2_sat_tc2",    {7'd0, tc_s}, 8'h01);

    // down-count terminal and load clamp
    rev = 1'b1; load = 1'b1; load_val = 8'h01;
    cyc(1);
    load = 1'b0;
    cyc(4);
    chk("t3_down_zero", count_w, 8'h00);
    cyc(4);
    chk("t3_wrap_99",   count_w, 8'h99);
    chk("t3_sat_00",    count_s, 8'h00);
    chk("t3_sat_tc",    {7'd0, tc_s}, 8'h01);
    load = 1'b1; load_val = 8'hAF;
    cyc(1);
    load = 1'b0;
    chk("t3_clamp_w",   count_w, 8'h99);
    chk("t3_clamp_s",   count_s, 8'h99);

    // pause and resume keeps the partial period
    rev = 1'b0; load = 1'b1; load_val = 8'h10;
    cyc(1);
    load = 1'b0;
    cyc(2);
    run = 1'b0;
    cyc(10);
    chk("t4_paused",    count_w, 8'h10);
    run = 1'b1;
    cyc(1);
    chk("t4_resume1",   count_w, 8'h10);
    cyc(1);
    chk("t4_resume2",   count_w, 8'h11);
    chk("t4_tick",      {7'd0, tick_w}, 8'h01);

    // lap on a step edge, then lap with clear
    load = 1'b1; load_val = 8'h05;
    cyc(1);
    load = 1'b0;
    cyc(3);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    chk("t5_count",     count_w, 8'h06);
    chk("t5_lap",       lap_w,   8'h05);
    chk("t5_lapv",      {7'd0, lv_w}, 8'h01);
    cyc(1);
    lap = 1'b1; clear = 1'b1;
    cyc(1);
    lap = 1'b0; clear = 1'b0;
    chk("t5_clr_lapv",  {7'd0, lv_w}, 8'h00);
    chk("t5_clr_count", count_w, 8'h00);

    // lap with load captures pre-load count; reset mid-count; clear beats load
    load = 1'b1; load_val = 8'h47; lap = 1'b1;
    cyc(1);
    load = 1'b0; lap = 1'b0;
    chk("t6_ldlap_lap",   lap_w,   8'h00);
    chk("t6_ldlap_count", count_w, 8'h47);
    chk("t6_ldlap_lapv",  {7'd0, lv_w}, 8'h01);
    reset = 1'b0;
    cyc(1);
    chk("t6_rst_count", count_w, 8'h00);
    chk("t6_rst_lapv",  {7'd0, lv_w}, 8'h00);
    chk("t6_rst_tick",  {7'd0, tick_w}, 8'h00);
    reset = 1'b1; clear = 1'b1; load = 1'b1; load_val = 8'h55;
    cyc(1);
    clear = 1'b0; load = 1'b0;
    chk("t6_clr_ld",    count_w, 8'h00);
    cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
